// File: rtl/lr35902_uart_tx_arb.sv
// Packet-granular arbiter sharing one UART byte transmitter among three requesters.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (0 > 1 > 2).
module lr35902_uart_tx_arb (
    input  logic        uart_clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_last,
    output logic [2:0]  req_ack,
    output logic [2:0]  grant,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy
);

    typedef enum logic [1:0] {IDLE, OWN, WAIT_HI, WAIT_LO} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_d, ack_d, win;
    logic        start_d, last_q, last_d;
    logic [7:0]  byte_d;
    logic [1:0]  owner_idx;
    logic        owner_req, owner_last;
    logic [7:0]  owner_data;
`ifdef UART_TX_ARB_RR_EN
    logic [1:0]  ptr_q, ptr_d;
`endif

    always_comb begin
        case (grant)
            3'b010:  owner_idx = 2'd1;
            3'b100:  owner_idx = 2'd2;
            default: owner_idx = 2'd0;
        endcase
        case (owner_idx)
            2'd1: begin
                owner_data = req_data[15:8];
                owner_last = req_last[1];
            end
            2'd2: begin
                owner_data = req_data[23:16];
                owner_last = req_last[2];
            end
            default: begin
                owner_data = req_data[7:0];
                owner_last = req_last[0];
            end
        endcase
        owner_req = |(req & grant);
    end

`ifdef UART_TX_ARB_RR_EN
    // Search starts just after the last released owner.
    always_comb begin
        win = '0;
        case (ptr_q)
            2'd0: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd1: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        win = '0;
        if      (req[0]) win = 3'b001;
        else if (req[1]) win = 3'b010;
        else if (req[2]) win = 3'b100;
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        ack_d   = '0;
        start_d = 1'b0;
        byte_d  = tx_byte;
        last_d  = last_q;
`ifdef UART_TX_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = win;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (owner_req) begin
                    if (!tx_busy) begin
                        byte_d  = owner_data;
                        last_d  = owner_last;
                        start_d = 1'b1;
                        ack_d   = grant;
                        state_d = WAIT_HI;
                    end
                end else begin
                    grant_d = '0;
`ifdef UART_TX_ARB_RR_EN
                    ptr_d   = owner_idx;
`endif
                    state_d = IDLE;
                end
            end
            WAIT_HI: begin
                if (tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
`ifdef UART_TX_ARB_RR_EN
                        ptr_d   = owner_idx;
`endif
                        state_d = IDLE;
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant    <= '0;
            req_ack  <= '0;
            tx_start <= 1'b0;
            tx_byte  <= '0;
            last_q   <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
            ptr_q    <= 2'd2;
`endif
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            req_ack  <= ack_d;
            tx_start <= start_d;
            tx_byte  <= byte_d;
            last_q   <= last_d;
`ifdef UART_TX_ARB_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_lr35902_uart_tx_arb.sv
// Scoreboard bench for lr35902_uart_tx_arb with requester queues and a 10-cycle busy transmitter model.
module tb_lr35902_uart_tx_arb;

    localparam int BUSY_CYCLES = 10;
    localparam int GAP_CYCLES  = BUSY_CYCLES + 2;

    logic        uart_clk = 1'b0;
    logic        reset    = 1'b1;
    logic [2:0]  req      = '0;
    logic [23:0] req_data = '0;
    logic [2:0]  req_last = '0;
    logic [2:0]  req_ack;
    logic [2:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_busy  = 1'b0;

    lr35902_uart_tx_arb dut (
        .uart_clk (uart_clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    typedef struct {
        int         who;
        logic [7:0] data;
        bit         lat;
        bit         gap;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  rq0[$], rq1[$], rq2[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rise[3];
    int          last_start = 0;
    int          tx_count = 0;
    int          busy_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_byte(input int n, input logic [7:0] d, input bit last);
        case (n)
            0:       rq0.push_back({last, d});
            1:       rq1.push_back({last, d});
            default: rq2.push_back({last, d});
        endcase
    endtask

    task automatic expect_tx(input int who, input logic [7:0] d, input bit lat, input bit gap);
        exp_t e;
        e.who = who; e.data = d; e.lat = lat; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic drive_reqs();
        logic [2:0] nr;
        nr = '0;
        req_data = '0;
        req_last = '0;
        if (rq0.size() != 0) begin nr[0] = 1'b1; req_data[7:0]   = rq0[0][7:0]; req_last[0] = rq0[0][8]; end
        if (rq1.size() != 0) begin nr[1] = 1'b1; req_data[15:8]  = rq1[0][7:0]; req_last[1] = rq1[0][8]; end
        if (rq2.size() != 0) begin nr[2] = 1'b1; req_data[23:16] = rq2[0][7:0]; req_last[2] = rq2[0][8]; end
        for (int n = 0; n < 3; n++)
            if (nr[n] && !req[n]) rise[n] = cyc;
        req = nr;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || grant != 0 || tx_busy || req != 0) && n < 400) begin
            @(negedge uart_clk); #1;
            n++;
        end
        if (n >= 400) check("idle_timeout_sb_depth", 32'(sb.size()), 0);
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_count < target && n < 200) begin
            @(negedge uart_clk); #1;
            n++;
        end
        if (n >= 200) check("tx_start_timeout", 32'(tx_count), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge uart_clk); #1;
        reset = 1'b1;
        @(negedge uart_clk); #1;
        reset = 1'b0;
    endtask

    // Monitor, transmitter model and requester driver, all stepped on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge uart_clk);
            cyc++;
            if (tx_start) begin
                tx_count++;
                if (sb.size() == 0) begin
                    check("unexpected_tx_start", 32'(tx_start), 0);
                end else begin
                    e = sb.pop_front();
                    check("tx_byte", 32'(tx_byte), 32'(e.data));
                    check("req_ack", 32'(req_ack), 32'(1) << e.who);
                    check("grant", 32'(grant), 32'(1) << e.who);
                    if (e.lat) check("start_latency", 32'(cyc - rise[e.who]), 2);
                    if (e.gap) check("byte_gap", 32'(cyc - last_start), 32'(GAP_CYCLES));
                end
                last_start = cyc;
            end else if (req_ack != 0) begin
                check("stray_ack", 32'(req_ack), 0);
            end
            if (!$onehot0(grant)) check("grant_onehot", 32'($onehot0(grant)), 1);

            if (req_ack[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (req_ack[1] && rq1.size() != 0) void'(rq1.pop_front());
            if (req_ack[2] && rq2.size() != 0) void'(rq2.pop_front());

            if (tx_start) busy_cnt = BUSY_CYCLES;
            tx_busy = (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;

            drive_reqs();
        end
    end

    initial begin
        int base;
        for (int n = 0; n < 3; n++) rise[n] = 0;
        repeat (3) @(negedge uart_clk);
        #1;
        check("rst_grant", 32'(grant), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_req_ack", 32'(req_ack), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        reset = 1'b0;

        // Single-byte packet, two-cycle latency, release after busy.
        push_byte(0, 8'h5A, 1'b1);
        expect_tx(0, 8'h5A, 1'b1, 1'b0);
        drive_reqs();
        wait_idle();

        // All three requesting with single-byte packets.
        do_reset();
        push_byte(0, 8'h01, 1'b1);
        push_byte(0, 8'h02, 1'b1);
        push_byte(0, 8'h03, 1'b1);
        push_byte(1, 8'h10, 1'b1);
        push_byte(2, 8'h20, 1'b1);
`ifdef UART_TX_ARB_RR_EN
        expect_tx(0, 8'h01, 1'b1, 1'b0);
        expect_tx(1, 8'h10, 1'b0, 1'b0);
        expect_tx(2, 8'h20, 1'b0, 1'b0);
        expect_tx(0, 8'h02, 1'b0, 1'b0);
        expect_tx(0, 8'h03, 1'b0, 1'b0);
`else
        expect_tx(0, 8'h01, 1'b1, 1'b0);
        expect_tx(0, 8'h02, 1'b0, 1'b0);
        expect_tx(0, 8'h03, 1'b0, 1'b0);
        expect_tx(1, 8'h10, 1'b0, 1'b0);
        expect_tx(2, 8'h20, 1'b0, 1'b0);
`endif
        drive_reqs();
        wait_idle();

        // Multi-byte packet is not pre-empted by a higher-priority request.
        do_reset();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        expect_tx(1, 8'h11, 1'b1, 1'b0);
        expect_tx(1, 8'h22, 1'b0, 1'b1);
        expect_tx(1, 8'h33, 1'b0, 1'b1);
        expect_tx(0, 8'h44, 1'b0, 1'b0);
        base = tx_count;
        drive_reqs();
        wait_tx(base + 1);
        push_byte(0, 8'h44, 1'b1);
        drive_reqs();
        wait_idle();

        // Owner abandons an unfinished packet; next request is served.
        do_reset();
        push_byte(0, 8'hA1, 1'b0);
        expect_tx(0, 8'hA1, 1'b1, 1'b0);
        drive_reqs();
        wait_idle();
        push_byte(1, 8'hB1, 1'b1);
        expect_tx(1, 8'hB1, 1'b1, 1'b0);
        drive_reqs();
        wait_idle();

        // Reset while waiting for the transmitter to go idle.
        do_reset();
        push_byte(1, 8'h55, 1'b0);
        push_byte(1, 8'h66, 1'b1);
        expect_tx(1, 8'h55, 1'b1, 1'b0);
        base = tx_count;
        drive_reqs();
        wait_tx(base + 1);
        repeat (4) @(negedge uart_clk);
        #1;
        reset = 1'b1;
        rq1.delete();
        drive_reqs();
        @(negedge uart_clk); #1;
        check("midrst_grant", 32'(grant), 0);
        check("midrst_tx_start", 32'(tx_start), 0);
        check("midrst_req_ack", 32'(req_ack), 0);
        reset = 1'b0;
        wait_idle();
        push_byte(2, 8'h77, 1'b1);
        expect_tx(2, 8'h77, 1'b1, 1'b0);
        drive_reqs();
        wait_idle();

        do_reset();
        push_byte(0, 8'h88, 1'b1);
        push_byte(2, 8'h99, 1'b1);
        expect_tx(0, 8'h88, 1'b1, 1'b0);
        expect_tx(2, 8'h99, 1'b0, 1'b0);
        drive_reqs();
        wait_idle();

        repeat (5) @(negedge uart_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lr35902_uart_tx_arb.md
LR35902_UART_TX_ARB -- requirements
Module: lr35902_uart_tx_arb

Interface
REQ-001 SHALL have port: uart_clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on uart_clk.
REQ-003 SHALL have port: req  in  3  per-requester byte-valid; bit n belongs to requester n.
REQ-004 SHALL have port: req_data  in  24  byte of requester n on bits [8n+7:8n].
REQ-005 SHALL have port: req_last  in  3  bit n high marks the offered byte as the last of the packet.
REQ-006 SHALL have port: req_ack  out  3  one-cycle pulse on bit n when requester n's byte is taken.
REQ-007 SHALL have port: grant  out  3  one-hot current owner; 0 when idle.
REQ-008 SHALL have port: tx_start  out  1  one-cycle pulse to the byte transmitter.
REQ-009 SHALL have port: tx_byte  out  8  byte to send; valid while tx_start is high and held afterwards.
REQ-010 SHALL have port: tx_busy  in  1  high while the transmitter is sending.

Function
REQ-011 SHALL implement states IDLE, OWN, WAIT_HI and WAIT_LO.
REQ-012 SHALL share the single UART transmitter among three requesters at packet granularity.
REQ-013 IDLE: when any req bit is high, SHALL register the winner into grant and enter OWN on the next edge.
REQ-014 IDLE with req==0: grant SHALL stay 0.
REQ-015 OWN with req[g] high and tx_busy low: on the next edge, SHALL latch tx_byte=req_data[g] and last=req_last[g], pulse tx_start and req_ack[g] for exactly one cycle, and enter WAIT_HI.
REQ-016 OWN with req[g] high and tx_busy high: SHALL stay in OWN with no ack.
REQ-017 OWN with req[g] low: SHALL drop the packet, clear grant, update the round-robin pointer to g and enter IDLE.
REQ-018 WAIT_HI: SHALL wait for tx_busy==1, then enter WAIT_LO.
REQ-019 WAIT_LO: SHALL wait for tx_busy==0; then, if the latched last is high, SHALL clear grant, set pointer=g and enter IDLE; otherwise SHALL return to OWN.
REQ-020 A granted packet SHALL NOT be pre-empted by any other request.
REQ-021 Non-owners SHALL receive no req_ack.
REQ-022 Latency from req in IDLE to tx_start SHALL be exactly 2 cycles when tx_busy is low.
REQ-023 Back-to-back bytes of one packet SHALL be separated only by the transmitter's busy time plus 2 cycles.
REQ-024 Simultaneous requests in IDLE SHALL be resolved by the policy of REQ-030.
REQ-025 A request that rises in the same cycle the owner releases SHALL be seen in the following IDLE cycle.
REQ-026 req_ack SHALL never be asserted for more than one cycle per byte.
REQ-027 At most one bit of grant and of req_ack SHALL be high in any cycle.

Reset
REQ-028 reset high SHALL force state=IDLE, grant=0, req_ack=0, tx_start=0, tx_byte=0, latched last=0, pointer=2 (requester 0 therefore wins first), overriding all other updates in that cycle.
REQ-029 Reset asserted mid-packet SHALL abandon the packet without a further tx_start; the transmitter's current byte is not the arbiter's concern.

Configuration
REQ-030 Macro UART_TX_ARB_RR_EN SHALL select the arbitration policy.
REQ-031 With UART_TX_ARB_RR_EN defined, the winner SHALL be the first requesting index in the order pointer+1, pointer+2, pointer+3 (mod 3).
REQ-032 Without UART_TX_ARB_RR_EN, priority SHALL be fixed (requester 0 highest, then 1, then 2) and the pointer SHALL be absent.

Verification
REQ-033 Reset, then req=3'b001 with data 0x5A and last=1, tx_busy model 10 cycles -> tx_start at cycle +2 with tx_byte=0x5A, req_ack=3'b001 in the same cycle, grant returns to 0 after busy falls.
REQ-034 req=3'b111 held with all last=1 (RR build) -> grant order 0,1,2,0; fixed build -> 0,0,0.
REQ-035 Requester 1 sends 3-byte packet 0x11,0x22,0x33 (last on third) while requester 0 requests from the second byte -> bytes 0x11,0x22,0x33 are sent before requester 0 is granted.
REQ-036 Owner drops req in OWN after the first byte of an unfinished packet -> grant=0 on the next edge with no further tx_start, and the next request is served.
REQ-037 Reset pulsed during WAIT_LO -> grant=0, tx_start=0 on the next edge; a fresh req=3'b100 is then granted to requester 2 only if requester 0 is not requesting.
